// File: rtl/t_flip_flop_pkg.sv
// Shared types for the toggle flip-flop bank: per-edge action decode used by
// both the bit cells and the top-level toggle-event counter.
package t_flip_flop_pkg;

   typedef enum logic [1:0] {
      ACT_HOLD   = 2'b00,
      ACT_TOGGLE = 2'b01,
      ACT_LOAD   = 2'b10
   } ff_action_e;

   // Load outranks enable; with neither asserted the state holds regardless of t.
   function automatic ff_action_e decode_action(input logic load, input logic en);
      ff_action_e act;
      if (load == 1'b1) begin
         act = ACT_LOAD;
      end else if (en == 1'b1) begin
         act = ACT_TOGGLE;
      end else begin
         act = ACT_HOLD;
      end
      return act;
   endfunction

endpackage

// File: rtl/t_flip_flop_cell.sv
// Single-bit T flip-flop with asynchronous active-low reset to a supplied
// reset value, synchronous load and enable-gated toggle.
module t_ff_cell
   import t_flip_flop_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_rst_val,
   input  logic i_t,
   input  logic i_en,
   input  logic i_load,
   input  logic i_load_val,
   output logic o_q
);

   logic       r_q;
   ff_action_e w_action;

   assign w_action = decode_action(i_load, i_en);

   // State register: async clear wins over any synchronous action.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q <= i_rst_val;
      end else begin
         case (w_action)
            ACT_LOAD:   r_q <= i_load_val;
            ACT_TOGGLE: r_q <= r_q ^ i_t;
            ACT_HOLD:   r_q <= r_q;
            default:    r_q <= r_q;
         endcase
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/t_flip_flop.sv
// Bank of WIDTH toggle flip-flops with parallel load, complementary output and
// a saturating count of edges on which at least one bit toggled.
module t_flip_flop
   import t_flip_flop_pkg::*;
#(
   parameter int                     WIDTH     = 1,
   parameter int                     CNT_W     = 16,
   parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] t,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic [CNT_W-1:0] toggle_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [WIDTH-1:0] w_q;
   logic             w_toggle_any;
   logic [CNT_W-1:0] r_cnt;

   genvar g;
   generate
      for (g = 0; g < WIDTH; g++) begin : g_cell
         t_ff_cell u_cell (
            .i_clk      (clk),
            .i_rst_n    (reset_n),
            .i_rst_val  (RESET_VAL[g]),
            .i_t        (t[g]),
            .i_en       (en),
            .i_load     (load),
            .i_load_val (load_val[g]),
            .o_q        (w_q[g])
         );
      end
   endgenerate

   // The action check comes first so an undriven t is masked when the bank is idle.
   assign w_toggle_any = (decode_action(load, en) == ACT_TOGGLE) && (|t);

   // Toggle-event counter, sticks at all-ones once reached.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (w_toggle_any && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CNT_ONE;
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign q          = w_q;
   assign qn         = ~w_q;
   assign toggle_cnt = r_cnt;

endmodule

// File: tb/tb_t_flip_flop.sv
// Directed bench for t_flip_flop: three instances cover single-bit toggling,
// per-bit behaviour with a non-zero reset value, and counter saturation.
module tb_t_flip_flop;

   logic        clk = 1'b0;
   logic        reset_n;

   logic        a_t, a_en, a_load, a_load_val;
   logic        a_q, a_qn;
   logic [15:0] a_cnt;

   logic [3:0]  b_t, b_load_val, b_q, b_qn;
   logic        b_en, b_load;
   logic [15:0] b_cnt;

   logic        c_t, c_en, c_load, c_load_val;
   logic        c_q, c_qn;
   logic [1:0]  c_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   t_flip_flop #(.WIDTH(1), .CNT_W(16), .RESET_VAL(1'b0)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .t(a_t), .en(a_en), .load(a_load),
      .load_val(a_load_val), .q(a_q), .qn(a_qn), .toggle_cnt(a_cnt)
   );

   t_flip_flop #(.WIDTH(4), .CNT_W(16), .RESET_VAL(4'b0101)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .t(b_t), .en(b_en), .load(b_load),
      .load_val(b_load_val), .q(b_q), .qn(b_qn), .toggle_cnt(b_cnt)
   );

   t_flip_flop #(.WIDTH(1), .CNT_W(2), .RESET_VAL(1'b0)) u_dut_c (
      .clk(clk), .reset_n(reset_n), .t(c_t), .en(c_en), .load(c_load),
      .load_val(c_load_val), .q(c_q), .qn(c_qn), .toggle_cnt(c_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b1;
      a_t = 1'b0; a_en = 1'b0; a_load = 1'b0; a_load_val = 1'b0;
      b_t = 4'b0000; b_en = 1'b0; b_load = 1'b0; b_load_val = 4'b0000;
      c_t = 1'b0; c_en = 1'b0; c_load = 1'b0; c_load_val = 1'b0;

      // Async reset before the first clock edge
      #2 reset_n = 1'b0;
      #1;
      check("rst_a_q",   32'(a_q),   32'h0);
      check("rst_a_qn",  32'(a_qn),  32'h1);
      check("rst_a_cnt", 32'(a_cnt), 32'h0);
      check("rst_b_q",   32'(b_q),   32'h5);
      check("rst_b_qn",  32'(b_qn),  32'hA);
      check("rst_c_cnt", 32'(c_cnt), 32'h0);
      tick;
      check("rst_hold_a_q", 32'(a_q), 32'h0);
      check("rst_hold_b_q", 32'(b_q), 32'h5);

      @(negedge clk);
      reset_n = 1'b1;
      a_en = 1'b1; a_t = 1'b1;
      c_en = 1'b1; c_t = 1'b1;
      b_load = 1'b1; b_load_val = 4'b0000;

      tick;
      check("tog1_a_q",  32'(a_q),   32'h1);
      check("tog1_a_qn", 32'(a_qn),  32'h0);
      check("sat1_c",    32'(c_cnt), 32'h1);
      check("ld0_b_q",   32'(b_q),   32'h0);
      check("ld0_b_cnt", 32'(b_cnt), 32'h0);
      b_load = 1'b0; b_en = 1'b1; b_t = 4'b1010;

      tick;
      check("tog2_a_q", 32'(a_q),   32'h0);
      check("sat2_c",   32'(c_cnt), 32'h2);
      check("bit1_b_q", 32'(b_q),   32'hA);
      b_t = 4'b0110;

      tick;
      check("tog3_a_q",  32'(a_q),   32'h1);
      check("sat3_c",    32'(c_cnt), 32'h3);
      check("bit2_b_q",  32'(b_q),   32'hC);
      check("bit2_b_qn", 32'(b_qn),  32'h3);
      check("bit2_b_cnt", 32'(b_cnt), 32'h2);
      b_load = 1'b1; b_load_val = 4'b0111; b_en = 1'b1; b_t = 4'b1111;

      tick;
      check("tog4_a_q",  32'(a_q),   32'h0);
      check("tog4_a_cnt", 32'(a_cnt), 32'h4);
      check("sat4_c",    32'(c_cnt), 32'h3);
      check("ldpri_b_q", 32'(b_q),   32'h7);
      check("ldpri_b_cnt", 32'(b_cnt), 32'h2);
      a_en = 1'b0;
      b_load = 1'b0; b_en = 1'b0;

      tick;
      check("sat5_c",    32'(c_cnt), 32'h3);
      check("sat5_c_q",  32'(c_q),   32'h1);
      c_en = 1'b0;

      // en low with t changing every half clock: q and count frozen
      for (int i = 0; i < 6; i++) begin
         a_t = ~a_t;
         @(negedge clk);
         a_t = ~a_t;
         tick;
         check("hold_en0_a_q", 32'(a_q), 32'h0);
      end
      check("hold_en0_a_cnt", 32'(a_cnt), 32'h4);

      a_t = 1'bx;
      tick;
      tick;
      check("hold_x_a_q",   32'(a_q),   32'h0);
      check("hold_x_a_cnt", 32'(a_cnt), 32'h4);

      a_en = 1'b1; a_t = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         check("hold_t0_a_q", 32'(a_q), 32'h0);
      end
      check("hold_t0_a_cnt", 32'(a_cnt), 32'h4);

      a_t = 1'b1;
      tick;
      check("pre_rst_a_q",   32'(a_q),   32'h1);
      check("pre_rst_a_cnt", 32'(a_cnt), 32'h5);

      // Mid-cycle async reset, then an edge with load pending while held
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_a_q",   32'(a_q),   32'h0);
      check("mid_rst_a_qn",  32'(a_qn),  32'h1);
      check("mid_rst_a_cnt", 32'(a_cnt), 32'h0);
      check("mid_rst_c_cnt", 32'(c_cnt), 32'h0);
      check("mid_rst_b_q",   32'(b_q),   32'h5);
      a_load = 1'b1; a_load_val = 1'b1;
      tick;
      check("rst_over_load_a_q", 32'(a_q), 32'h0);

      @(negedge clk);
      reset_n = 1'b1;
      a_load = 1'b0; a_en = 1'b1; a_t = 1'b1;
      tick;
      check("post_rst_a_q",   32'(a_q),   32'h1);
      check("post_rst_a_cnt", 32'(a_cnt), 32'h1);

      a_load = 1'b1; a_load_val = 1'b0;
      tick;
      check("ld_a_q",   32'(a_q),   32'h0);
      check("ld_a_cnt", 32'(a_cnt), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
